// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state, lamp and phase encodings for the traffic sequencer
package traffic_pkg;

    localparam logic [2:0] ST_INIT      = 3'd0;
    localparam logic [2:0] ST_FLASH     = 3'd1;
    localparam logic [2:0] ST_NS_GREEN  = 3'd2;
    localparam logic [2:0] ST_NS_YELLOW = 3'd3;
    localparam logic [2:0] ST_EW_GREEN  = 3'd4;
    localparam logic [2:0] ST_EW_YELLOW = 3'd5;

    typedef enum logic [2:0] {
        INIT      = ST_INIT,
        FLASH     = ST_FLASH,
        NS_GREEN  = ST_NS_GREEN,
        NS_YELLOW = ST_NS_YELLOW,
        EW_GREEN  = ST_EW_GREEN,
        EW_YELLOW = ST_EW_YELLOW
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam logic [1:0] PH_NS_GREEN  = 2'd0;
    localparam logic [1:0] PH_NS_YELLOW = 2'd1;
    localparam logic [1:0] PH_EW_GREEN  = 2'd2;
    localparam logic [1:0] PH_EW_YELLOW = 2'd3;

    // A zero duration from the switches would stall the countdown, so it means 1 s.
    function automatic logic [3:0] clamp_sec(input logic [3:0] s);
        return (s == 4'd0) ? 4'd1 : s;
    endfunction

    function automatic logic [5:0] lamps_of(input state_t s);
        logic [5:0] r;
        r = {LAMP_RED, LAMP_RED};
        case (s)
            NS_GREEN:  r = {LAMP_GRN, LAMP_RED};
            NS_YELLOW: r = {LAMP_YEL, LAMP_RED};
            EW_GREEN:  r = {LAMP_RED, LAMP_GRN};
            EW_YELLOW: r = {LAMP_RED, LAMP_YEL};
            default:   r = {LAMP_RED, LAMP_RED};
        endcase
        return r;
    endfunction

    function automatic logic [1:0] phase_of(input state_t s);
        logic [1:0] r;
        r = PH_NS_GREEN;
        case (s)
            NS_YELLOW: r = PH_NS_YELLOW;
            EW_GREEN:  r = PH_EW_GREEN;
            EW_YELLOW: r = PH_EW_YELLOW;
            default:   r = PH_NS_GREEN;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_tick_gen.sv
// rtl/traffic_phase_ctrl_tick_gen.sv - clearable 1 s prescaler producing a one-cycle tick
module tick_gen #(
    parameter int TICK_CYCLES = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Masked by clr so a count left over from before the clear never leaks a tick.
    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - four-phase two-road light sequencer with pedestrian shortening and flash mode
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set,
    input  logic [3:0] green_sec,
    input  logic [3:0] yellow_sec,
    input  logic       ped_req,
    output logic [2:0] light_ns,
    output logic [2:0] light_ew,
    output logic [3:0] remain_sec,
    output logic [1:0] phase,
    output logic       tick
);

    state_t     state;
    state_t     nxt_run;
    logic [3:0] nxt_dur;
    logic       is_green;
    logic       blink;
    logic       blink_tick;
    logic       ped_pend;
    logic       run_clr;
    logic       flash_clr;

    assign run_clr   = (state == INIT) || (state == FLASH);
    assign flash_clr = (state != FLASH);
    assign is_green  = (state == NS_GREEN) || (state == EW_GREEN);

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_phase_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (run_clr),
        .tick (tick)
    );

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_blink_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (flash_clr),
        .tick (blink_tick)
    );

    always_comb begin
        nxt_run = NS_GREEN;
        case (state)
            NS_GREEN:  nxt_run = NS_YELLOW;
            NS_YELLOW: nxt_run = EW_GREEN;
            EW_GREEN:  nxt_run = EW_YELLOW;
            default:   nxt_run = NS_GREEN;
        endcase
        nxt_dur = is_green ? clamp_sec(yellow_sec) : clamp_sec(green_sec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            light_ns   <= LAMP_RED;
            light_ew   <= LAMP_RED;
            remain_sec <= 4'd0;
            phase      <= PH_NS_GREEN;
            blink      <= 1'b0;
            ped_pend   <= 1'b0;
        end else begin
            case (state)
                INIT, FLASH: begin
                    ped_pend <= 1'b0;
                    if (set) begin
                        // blink is 0 in INIT and blink_tick only fires in FLASH
                        state      <= FLASH;
                        blink      <= blink ^ blink_tick;
                        light_ns   <= {1'b0, blink ^ blink_tick, 1'b0};
                        light_ew   <= {1'b0, blink ^ blink_tick, 1'b0};
                        remain_sec <= 4'd0;
                        phase      <= PH_NS_GREEN;
                    end else begin
                        state                <= NS_GREEN;
                        blink                <= 1'b0;
                        remain_sec           <= clamp_sec(green_sec);
                        phase                <= PH_NS_GREEN;
                        {light_ns, light_ew} <= lamps_of(NS_GREEN);
                    end
                end
                default: begin
                    if (set) begin
                        state      <= FLASH;
                        ped_pend   <= 1'b0;
                        remain_sec <= 4'd0;
                        phase      <= PH_NS_GREEN;
                        light_ns   <= LAMP_OFF;
                        light_ew   <= LAMP_OFF;
                    end else if (is_green && ped_pend && remain_sec > 4'd2) begin
                        // Pedestrian shortening wins over a coincident tick.
                        remain_sec <= 4'd2;
                        ped_pend   <= ped_req;
                    end else begin
                        ped_pend <= ped_pend | ped_req;
                        if (tick) begin
                            if (remain_sec > 4'd1) begin
                                remain_sec <= remain_sec - 4'd1;
                            end else begin
                                state                <= nxt_run;
                                remain_sec           <= nxt_dur;
                                phase                <= phase_of(nxt_run);
                                {light_ns, light_ew} <= lamps_of(nxt_run);
                                if (is_green) begin
                                    ped_pend <= ped_req;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - directed and randomized check of traffic_phase_ctrl against a phase-level model
module tb_traffic_phase_ctrl;

    localparam int TC = 4;
    localparam logic [2:0] NS_TAB [4] = '{3'b001, 3'b010, 3'b100, 3'b100};
    localparam logic [2:0] EW_TAB [4] = '{3'b100, 3'b100, 3'b001, 3'b010};

    logic       clk = 1'b0;
    logic       rst;
    logic       set;
    logic [3:0] green_sec;
    logic [3:0] yellow_sec;
    logic       ped_req;
    logic [2:0] light_ns;
    logic [2:0] light_ew;
    logic [3:0] remain_sec;
    logic [1:0] phase;
    logic       tick;

    int vectors = 0;
    int miscompares = 0;

    // Model: mode 0=init 1=flash 2=run; ph indexes the four road phases.
    int m_mode, m_ph, m_rem, m_cnt, m_bcnt;
    bit m_pend, m_blink;

    always #10 clk = ~clk;

    traffic_phase_ctrl #(.TICK_CYCLES(TC)) dut (
        .clk        (clk),
        .rst        (rst),
        .set        (set),
        .green_sec  (green_sec),
        .yellow_sec (yellow_sec),
        .ped_req    (ped_req),
        .light_ns   (light_ns),
        .light_ew   (light_ew),
        .remain_sec (remain_sec),
        .phase      (phase),
        .tick       (tick)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int dur(input int ph);
        int s;
        s = (ph % 2 == 0) ? int'(green_sec) : int'(yellow_sec);
        return (s == 0) ? 1 : s;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ph = 0; m_rem = 0; m_cnt = 0; m_bcnt = 0;
        m_pend = 0; m_blink = 0;
    endtask

    task automatic model_edge();
        bit tk, bt;
        tk = (m_mode == 2) && (m_cnt == TC - 1);
        bt = (m_mode == 1) && (m_bcnt == TC - 1);
        m_cnt  = (m_mode == 2) ? (m_cnt + 1) % TC : 0;
        m_bcnt = (m_mode == 1) ? (m_bcnt + 1) % TC : 0;
        if (m_mode != 2) begin
            m_pend = 0;
            if (set) begin
                if (m_mode == 1 && bt) m_blink = !m_blink;
                m_mode = 1;
            end else begin
                m_mode = 2; m_ph = 0; m_rem = dur(0); m_blink = 0;
            end
        end else if (set) begin
            m_mode = 1; m_pend = 0;
        end else if (m_ph % 2 == 0 && m_pend && m_rem > 2) begin
            m_rem = 2; m_pend = ped_req;
        end else begin
            if (ped_req) m_pend = 1;
            if (tk) begin
                if (m_rem > 1) m_rem = m_rem - 1;
                else begin
                    if (m_ph % 2 == 0) m_pend = ped_req;
                    m_ph = (m_ph + 1) % 4;
                    m_rem = dur(m_ph);
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [2:0] ens, eew;
        logic [3:0] erem;
        logic [1:0] eph;
        logic       etk;
        if (m_mode == 0) begin
            ens = 3'b100; eew = 3'b100; erem = 4'd0; eph = 2'd0;
        end else if (m_mode == 1) begin
            ens = {1'b0, m_blink, 1'b0}; eew = ens; erem = 4'd0; eph = 2'd0;
        end else begin
            ens = NS_TAB[m_ph]; eew = EW_TAB[m_ph]; erem = 4'(m_rem); eph = 2'(m_ph);
        end
        etk = (m_mode == 2) && (m_cnt == TC - 1);
        check("light_ns", 8'(light_ns), 8'(ens));
        check("light_ew", 8'(light_ew), 8'(eew));
        check("remain_sec", 8'(remain_sec), 8'(erem));
        check("phase", 8'(phase), 8'(eph));
        check("tick", 8'(tick), 8'(etk));
    endtask

    task automatic cyc(input bit p);
        @(negedge clk);
        ped_req = p;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0);
    endtask

    task automatic wait_phase(input int ph, input string tag);
        for (int i = 0; i < 200; i++) begin
            if (m_mode == 2 && m_ph == ph) break;
            cyc(1'b0);
        end
        check(tag, 8'(phase), 8'(ph));
    endtask

    initial begin
        rst = 1'b1; set = 1'b0; ped_req = 1'b0;
        green_sec = 4'd3; yellow_sec = 4'd1;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // Basic 3/1 cycle: 8 ticks per full rotation.
        run(2 * 8 * TC + 4);

        // Zero durations clamp to one second each.
        green_sec = 4'd0; yellow_sec = 4'd0;
        run(6 * TC);

        // Pedestrian request early in a long green, then one at remain 2.
        set = 1'b1; green_sec = 4'd9; yellow_sec = 4'd3;
        run(3);
        set = 1'b0;
        cyc(1'b0);
        check("ped_entry_remain", 8'(remain_sec), 8'd9);
        cyc(1'b1);
        run(3 * TC + 2);
        cyc(1'b1);
        run(2 * TC);

        // Request during yellow carries into the next green.
        wait_phase(3, "reach_ew_yellow");
        wait_phase(1, "reach_ns_yellow");
        cyc(1'b1);
        wait_phase(2, "reach_ew_green");
        check("ew_green_entry_remain", 8'(remain_sec), 8'd9);
        cyc(1'b0);
        check("ew_green_ped_remain", 8'(remain_sec), 8'd2);
        run(TC + 1);

        // Flash mode then restart.
        set = 1'b1;
        run(5 * TC);
        set = 1'b0;
        run(3 * TC);

        // Asynchronous reset in the middle of NS_YELLOW.
        wait_phase(1, "reach_ns_yellow_rst");
        @(negedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
        run(TC + 2);

        // Randomized traffic with occasional set toggles and config changes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) set = ~set;
            if ($urandom_range(0, 9) == 0) green_sec = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) yellow_sec = 4'($urandom_range(0, 15));
            cyc($urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
